// File: rtl/seg7_decoder.sv
// Two-digit 7-segment pattern decoder: accepts a display pattern once it has been stable, emits it once.
// Optional err_count output is enabled by defining SEG7_DECODER_ERRCNT_EN.
module seg7_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] HEX0,
    input  logic [6:0] HEX1,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] num,
    output logic       err
`ifdef SEG7_DECODER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam logic [13:0] BLANK  = 14'h3FFF;
    localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);

    typedef enum logic {TRACK, EMIT} state_t;

    state_t      state_q, state_d;
    logic [13:0] held_q, held_d;
    logic [13:0] last_q, last_d;
    logic        last_vld_q, last_vld_d;
    logic [3:0]  count_q, count_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  num_q, num_d;
    logic        err_q, err_d;

    // Result is {invalid, digit}; invalid patterns decode to digit 0.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h03:   decode = 5'h0B;
            7'h27:   decode = 5'h0C;
            7'h21:   decode = 5'h0D;
            7'h06:   decode = 5'h0E;
            7'h0E:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    logic [13:0] sample;
    logic [4:0]  dec_hi, dec_lo;
    logic        emit_ok;
    logic        handshake;

    assign sample    = {HEX1, HEX0};
    assign dec_hi    = decode(held_q[13:7]);
    assign dec_lo    = decode(held_q[6:0]);
    assign emit_ok   = (count_q == STABLE) && (!last_vld_q || (held_q != last_q)) && (held_q != BLANK);
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        last_d      = last_q;
        last_vld_d  = last_vld_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        num_d       = num_q;
        err_d       = err_q;
        case (state_q)
            TRACK: begin
                if (emit_ok) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    num_d       = {dec_hi[3:0], dec_lo[3:0]};
                    err_d       = dec_hi[4] | dec_lo[4];
                end else if (sample == held_q) begin
                    if (count_q < STABLE) begin
                        count_d = count_q + 4'd1;
                    end
                end else begin
                    held_d  = sample;
                    count_d = 4'd1;
                end
            end
            EMIT: begin
                // Inputs are ignored here; tracking resumes from scratch after the handshake.
                if (handshake) begin
                    state_d     = TRACK;
                    out_valid_d = 1'b0;
                    last_d      = held_q;
                    last_vld_d  = 1'b1;
                    count_d     = 4'd0;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= TRACK;
            held_q      <= BLANK;
            last_q      <= BLANK;
            last_vld_q  <= 1'b0;
            count_q     <= 4'd0;
            out_valid_q <= 1'b0;
            num_q       <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            num_q       <= num_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign num       = num_q;
    assign err       = err_q;

`ifdef SEG7_DECODER_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (handshake && err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// Bench for seg7_decoder: directed scenarios plus random patterns, scoreboarded against a reference model.
module tb_seg7_decoder;
    localparam int S = 4;
    localparam logic [13:0] BLANK = 14'h3FFF;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    localparam logic [6:0] POOL [6] = '{7'h40, 7'h79, 7'h24, 7'h7F, 7'h55, 7'h00};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] HEX0 = 7'h7F;
    logic [6:0] HEX1 = 7'h7F;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] num;
    logic       err;
`ifdef SEG7_DECODER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    seg7_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .num       (num),
        .err       (err)
`ifdef SEG7_DECODER_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] wnum;
        logic       werr;
    } word_t;
    word_t exp_q[$];

    function automatic logic [4:0] ref_digit(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (SEG_TAB[i] == p) return {1'b0, 4'(i)};
        end
        return 5'h10;
    endfunction

    // Reference model: a display is accepted after S identical samples, then offered once.
    bit          m_emit = 1'b0;
    logic [13:0] m_pat = BLANK;
    logic [13:0] m_last = BLANK;
    bit          m_has_last = 1'b0;
    int          m_run = 0;
    int          m_errs = 0;
    word_t       m_word;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_emit = 1'b0;
            m_pat = BLANK;
            m_has_last = 1'b0;
            m_run = 0;
            m_errs = 0;
            exp_q.delete();
        end else if (m_emit) begin
            if (out_ready) begin
                m_emit = 1'b0;
                m_last = m_pat;
                m_has_last = 1'b1;
                m_run = 0;
                if (m_word.werr && m_errs < 255) m_errs = m_errs + 1;
            end
        end else if (m_run >= S && !(m_has_last && m_pat == m_last) && m_pat != BLANK) begin
            logic [4:0] d1, d0;
            d1 = ref_digit(m_pat[13:7]);
            d0 = ref_digit(m_pat[6:0]);
            m_word.wnum = {d1[3:0], d0[3:0]};
            m_word.werr = d1[4] | d0[4];
            m_emit = 1'b1;
            exp_q.push_back(m_word);
        end else if ({HEX1, HEX0} == m_pat) begin
            m_run = m_run + 1;
        end else begin
            m_pat = {HEX1, HEX0};
            m_run = 1;
        end
    end

    // Monitor: samples just after each rising edge.
    initial begin
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== m_emit) begin
                errors++;
                $display("FAIL valid_timing t=%0t: out_valid=%0b required %0b", $time, out_valid, m_emit);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word t=%0t: num=%02h err=%0b with nothing expected", $time, num, err);
                end else if (num !== exp_q[0].wnum || err !== exp_q[0].werr) begin
                    errors++;
                    $display("FAIL word t=%0t: num=%02h err=%0b required num=%02h err=%0b",
                             $time, num, err, exp_q[0].wnum, exp_q[0].werr);
                end
            end else if (prev_valid && exp_q.size() > 0) begin
                $display("word consumed t=%0t: num=%02h err=%0b", $time, exp_q[0].wnum, exp_q[0].werr);
                void'(exp_q.pop_front());
            end
`ifdef SEG7_DECODER_ERRCNT_EN
            checks++;
            if (err_count !== 8'(m_errs)) begin
                errors++;
                $display("FAIL err_count t=%0t: %0d required %0d", $time, err_count, m_errs);
            end
`endif
            prev_valid = (out_valid === 1'b1);
        end
    end

    task automatic drive(input logic [6:0] h1, input logic [6:0] h0, input logic rdy, input int n);
        HEX1 = h1;
        HEX0 = h0;
        out_ready = rdy;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_word(input string name, input logic [7:0] n, input logic e);
        checks++;
        if (!(out_valid === 1'b1 && num === n && err === e)) begin
            errors++;
            $display("FAIL %s: valid=%0b num=%02h err=%0b required valid=1 num=%02h err=%0b",
                     name, out_valid, num, err, n, e);
        end
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: out_valid=%0b required 0", name, out_valid);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || num !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b num=%02h err=%0b required 0/00/0", out_valid, num, err);
        end
        reset = 1'b0;

        // Single stable pattern, accepted on the 5th edge, never repeated.
        drive(7'h24, 7'h08, 1'b1, S + 1);
        expect_word("stable_2A", 8'h2A, 1'b0);
        drive(7'h24, 7'h08, 1'b1, 1);
        expect_idle("one_cycle_2A");
        drive(7'h24, 7'h08, 1'b1, 20);
        expect_idle("no_reemit_2A");

        // Input that never settles long enough.
        for (int i = 0; i < 6; i++) begin
            drive(7'h40, 7'h79, 1'b1, 3);
            drive(7'h40, 7'h24, 1'b1, 3);
        end
        expect_idle("unstable");

        // Back-pressure: pending word held while inputs move.
        drive(7'h40, 7'h30, 1'b0, S + 1);
        expect_word("pending_03", 8'h03, 1'b0);
        drive(7'h12, 7'h12, 1'b0, 10);
        expect_word("held_03", 8'h03, 1'b0);
        drive(7'h12, 7'h12, 1'b1, S + 2);
        expect_word("after_hs_55", 8'h55, 1'b0);
        drive(7'h12, 7'h12, 1'b1, 1);
        expect_idle("consumed_55");

        // Blank display is idle; invalid digit decodes to 0 with err.
        drive(7'h7F, 7'h7F, 1'b1, 20);
        expect_idle("blank");
        drive(7'h40, 7'h55, 1'b1, S + 1);
        expect_word("invalid_digit", 8'h00, 1'b1);
        drive(7'h40, 7'h55, 1'b1, 1);
        expect_idle("consumed_err");

        // Repeat suppression and re-emission after a change.
        drive(7'h00, 7'h00, 1'b1, S + 1);
        expect_word("first_88", 8'h88, 1'b0);
        drive(7'h00, 7'h00, 1'b1, 20);
        expect_idle("no_second_88");
        drive(7'h06, 7'h0E, 1'b1, S + 1);
        expect_word("EF", 8'hEF, 1'b0);
        drive(7'h06, 7'h0E, 1'b1, 1);
        drive(7'h00, 7'h00, 1'b1, S + 1);
        expect_word("again_88", 8'h88, 1'b0);
        drive(7'h00, 7'h00, 1'b1, 1);

        // Asynchronous reset while a word is pending.
        drive(7'h79, 7'h79, 1'b0, S + 3);
        expect_word("pending_11", 8'h11, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || num !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b num=%02h err=%0b required 0/00/0", out_valid, num, err);
        end
        @(negedge clk);
        reset = 1'b0;

        // Random segments drawn from a small pool so repeats and returns occur.
        for (int i = 0; i < 300; i++) begin
            logic [6:0] h1, h0;
            h1 = POOL[$urandom_range(0, 5)];
            h0 = POOL[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) begin
                h1 = 7'h7F;
                h0 = 7'h7F;
            end
            drive(h1, h0, ($urandom_range(0, 3) != 0), $urandom_range(1, 8));
        end
        drive(7'h7F, 7'h7F, 1'b1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
